// File: rtl/reg_writeback_buffer.sv
// Write-back buffer: circular FIFO in front of the register-file write port, with read forwarding (WB_FORWARD_EN).
// Latency: an accepted entry is visible in count/forwarding next cycle and may drain that same cycle.
// Backpressure: wb_ready drops while full (from registered count only); rf_stall holds the head entry.
module reg_writeback_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic [4:0]               wb_dest,
    input  logic [31:0]              wb_data,
    input  logic                     rf_stall,
    output logic                     rf_we,
    output logic [4:0]               rf_dest,
    output logic [31:0]              rf_data,
    input  logic [4:0]               src1,
    input  logic [4:0]               src2,
    output logic                     fwd1_hit,
    output logic                     fwd2_hit,
    output logic [31:0]              fwd1_val,
    output logic [31:0]              fwd2_val,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [4:0]    dest_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          push;
    logic          pop;
    logic          not_empty;

    assign not_empty = (count != '0);
    assign wb_ready  = (count < FULL);
    // Register 0 is architecturally constant, so its write is acknowledged but never stored.
    assign push      = rst && wb_valid && wb_ready && (wb_dest != 5'd0);
    assign rf_we     = rst && not_empty && !rf_stall;
    assign pop       = rf_we;
    assign rf_dest   = not_empty ? dest_q[head] : 5'd0;
    assign rf_data   = not_empty ? data_q[head] : 32'd0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (!push && pop)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            dest_q[tail] <= wb_dest;
            data_q[tail] <= wb_data;
        end
    end

`ifdef WB_FORWARD_EN
    logic [AW-1:0] idx;

    // Walk oldest to youngest so the last match, the youngest write, wins.
    always_comb begin
        fwd1_hit = 1'b0;
        fwd1_val = '0;
        fwd2_hit = 1'b0;
        fwd2_val = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + AW'(i);
            if (CW'(i) < count) begin
                if (src1 != 5'd0 && dest_q[idx] == src1) begin
                    fwd1_hit = 1'b1;
                    fwd1_val = data_q[idx];
                end
                if (src2 != 5'd0 && dest_q[idx] == src2) begin
                    fwd2_hit = 1'b1;
                    fwd2_val = data_q[idx];
                end
            end
        end
    end
`else
    logic unused_src;

    assign unused_src = ^{src1, src2};
    assign fwd1_hit   = 1'b0;
    assign fwd2_hit   = 1'b0;
    assign fwd1_val   = '0;
    assign fwd2_val   = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_buffer.sv
// Self-checking bench for reg_writeback_buffer: directed scenarios then random traffic against a queue model.
module tb_reg_writeback_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        rf_stall;
    logic        rf_we;
    logic [4:0]  rf_dest;
    logic [31:0] rf_data;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic        fwd1_hit;
    logic        fwd2_hit;
    logic [31:0] fwd1_val;
    logic [31:0] fwd2_val;
    logic [2:0]  count;

    int vectors;
    int miscompares;

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];

    reg_writeback_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dest(wb_dest), .wb_data(wb_data),
        .rf_stall(rf_stall), .rf_we(rf_we), .rf_dest(rf_dest), .rf_data(rf_data),
        .src1(src1), .src2(src2),
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_val(fwd1_val), .fwd2_val(fwd2_val),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Youngest buffered write to src wins; register 0 never forwards.
    task automatic fwd_model(input logic [4:0] src, output logic hit, output logic [31:0] val);
        hit = 1'b0;
        val = 32'd0;
`ifdef WB_FORWARD_EN
        if (src != 5'd0)
            foreach (q[i])
                if (q[i].dest == src) begin
                    hit = 1'b1;
                    val = q[i].data;
                end
`endif
    endtask

    // Apply inputs (just after a negedge), settle, and compare every output against the model.
    task automatic drive(input logic r, input logic v, input logic [4:0] d, input logic [31:0] dat,
                         input logic st, input logic [4:0] s1, input logic [4:0] s2);
        logic        h;
        logic [31:0] fv;
        logic        exp_we;
        rst = r; wb_valid = v; wb_dest = d; wb_data = dat; rf_stall = st; src1 = s1; src2 = s2;
        #1;
        exp_we = r && (q.size() != 0) && !st;
        chk("wb_ready", wb_ready, (q.size() < DEPTH) ? 1 : 0);
        chk("count", count, q.size());
        chk("rf_we", rf_we, exp_we);
        chk("rf_dest", rf_dest, (q.size() != 0) ? q[0].dest : 5'd0);
        chk("rf_data", rf_data, (q.size() != 0) ? q[0].data : 32'd0);
        fwd_model(s1, h, fv);
        chk("fwd1_hit", fwd1_hit, h);
        chk("fwd1_val", fwd1_val, fv);
        fwd_model(s2, h, fv);
        chk("fwd2_hit", fwd2_hit, h);
        chk("fwd2_val", fwd2_val, fv);
    endtask

    // Advance one clock and update the model from the inputs that were presented.
    task automatic step();
        bit   rdy;
        ent_t e;
        @(posedge clk);
        if (!rst) begin
            q.delete();
        end else begin
            rdy = (q.size() < DEPTH);
            if (q.size() != 0 && !rf_stall)
                void'(q.pop_front());
            if (wb_valid && rdy && wb_dest != 5'd0) begin
                e.dest = wb_dest;
                e.data = wb_data;
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic st);
        drive(1'b1, 1'b0, 5'd0, 32'd0, st, 5'd0, 5'd0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b0; wb_valid = 1'b0; wb_dest = '0; wb_data = '0;
        rf_stall = 1'b0; src1 = '0; src2 = '0;
        @(posedge clk);
        @(negedge clk);

        // Reset cycle with a handshake present: it must be ignored.
        drive(1'b0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd9, 5'd0);
        step();
        idle(1'b0);
        chk("reset_count", count, 0);
        chk("reset_ready", wb_ready, 1);

        // Single push drains the following cycle.
        drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
        step();
        idle(1'b0);
        chk("single_count", count, 1);
        chk("single_we", rf_we, 1);
        chk("single_dest", rf_dest, 5);
        chk("single_data", rf_data, 32'hDEADBEEF);
        step();
        idle(1'b0);
        chk("single_empty", count, 0);

        // Fill while stalled; fifth request is refused.
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 1'b1, 5'(i), 32'(i * 16), 1'b1, 5'd0, 5'd0);
            if (i == 5) begin
                chk("full_ready", wb_ready, 0);
                chk("full_count", count, 4);
            end
            step();
        end
        // Drain in order; retry dest 5 while full (refused even though a pop happens) then accepted.
        for (int k = 1; k <= 5; k++) begin
            if (k <= 2)
                drive(1'b1, 1'b1, 5'd5, 32'h50, 1'b0, 5'd0, 5'd0);
            else
                idle(1'b0);
            if (k == 1) chk("full_pop_ready", wb_ready, 0);
            if (k == 2) begin
                chk("after_pop_ready", wb_ready, 1);
                chk("after_pop_count", count, 3);
            end
            chk("drain_order", rf_dest, k);
            step();
        end
        idle(1'b0);
        chk("drained", count, 0);
        step();

        // Write to register 0 completes without enqueuing.
        drive(1'b1, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd0);
        chk("r0_ready", wb_ready, 1);
        step();
        idle(1'b0);
        chk("r0_count", count, 0);
        chk("r0_we", rf_we, 0);
        step();

        // Two writes to the same register: youngest forwards; same-cycle request is not forwarded.
        drive(1'b1, 1'b1, 5'd7, 32'h11, 1'b1, 5'd0, 5'd0);
        step();
        drive(1'b1, 1'b1, 5'd7, 32'h22, 1'b1, 5'd0, 5'd0);
        step();
        drive(1'b1, 1'b1, 5'd7, 32'h33, 1'b1, 5'd7, 5'd0);
`ifdef WB_FORWARD_EN
        chk("fwd_young_hit", fwd1_hit, 1);
        chk("fwd_young_val", fwd1_val, 32'h22);
`else
        chk("fwd_off_hit", fwd1_hit, 0);
        chk("fwd_off_val", fwd1_val, 0);
`endif
        chk("fwd_src0_hit", fwd2_hit, 0);
        step();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd7);
            step();
        end

        // Reset with three entries pending: all discarded, nothing written.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 5'(k + 10), 32'(k + 100), 1'b1, 5'd0, 5'd0);
            step();
        end
        drive(1'b0, 1'b1, 5'd3, 32'h3, 1'b0, 5'd10, 5'd11);
        chk("rst_mid_we", rf_we, 0);
        step();
        idle(1'b0);
        chk("rst_mid_count", count, 0);
        chk("rst_mid_we_after", rf_we, 0);
        chk("rst_mid_ready", wb_ready, 1);
        step();
        for (int k = 0; k < 3; k++) begin
            idle(1'b0);
            step();
        end

        // Random traffic with a small register range to force forwarding collisions.
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 49) != 0), $urandom_range(0, 2) != 0,
                  5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
